// File: rtl/sbus_arb_if.sv
// -----------------------------------------------------------------------------
// sbus_arb_if -- bundle of the arbiter's master-side and wrapper-side signals.
//
// Parameters: NM masters, AW address bits, DW data bits, BW burst-count bits.
//
// Master side (per master k, packed as [k*W +: W]):
//   m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_burst_cnt_i  -> arbiter
//   m_dat_o, m_ack_o, m_err_o                                  <- arbiter
//   grant_o                                                    <- arbiter
// Wrapper side (single downstream port):
//   wrp_dat_i, wrp_ack_i, wrp_ack_bus_i                        -> arbiter
//   wrp_dat_o, wrp_adr_o, wrp_stb_o, wrp_we_o, wrp_sel_o,
//   wrp_burst_cnt_o                                            <- arbiter
//
// Modports: slave = arbiter view, master = environment view.
// -----------------------------------------------------------------------------
interface sbus_arb_if #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4
);
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM*BW-1:0] m_burst_cnt_i;
    logic [NM*DW-1:0] m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [NM-1:0]    grant_o;

    logic [DW-1:0]    wrp_dat_i;
    logic             wrp_ack_i;
    logic             wrp_ack_bus_i;
    logic [DW-1:0]    wrp_dat_o;
    logic [AW-1:0]    wrp_adr_o;
    logic             wrp_stb_o;
    logic             wrp_we_o;
    logic [3:0]       wrp_sel_o;
    logic [BW-1:0]    wrp_burst_cnt_o;

    modport slave (
        input  m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_burst_cnt_i,
        output m_dat_o, m_ack_o, m_err_o, grant_o,
        input  wrp_dat_i, wrp_ack_i, wrp_ack_bus_i,
        output wrp_dat_o, wrp_adr_o, wrp_stb_o, wrp_we_o, wrp_sel_o, wrp_burst_cnt_o
    );

    modport master (
        output m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_burst_cnt_i,
        input  m_dat_o, m_ack_o, m_err_o, grant_o,
        output wrp_dat_i, wrp_ack_i, wrp_ack_bus_i,
        input  wrp_dat_o, wrp_adr_o, wrp_stb_o, wrp_we_o, wrp_sel_o, wrp_burst_cnt_o
    );
endinterface

// File: rtl/sbus_arb.sv
// -----------------------------------------------------------------------------
// sbus_arb -- round-robin arbiter of NM bus masters onto one wrapper port.
//
// Masters (0 icache, 1 dcache, 2 bg by default) raise m_stb_i; from IDLE the
// arbiter grants the first requester after the last-served one, then passes
// the granted master's request straight through to the wrapper (address
// offset by ADR_OFS[k]) and routes wrapper data/acks back to that master
// only. The transaction ends on wrp_ack_bus_i, on the master dropping its
// strobe, or (optionally) on a timeout; an idle cycle always follows.
//
// Ports:
//   clk_i  - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - sbus_arb_if.slave, all master and wrapper signals
//
// Optional feature: define SBUS_ARB_TIMEOUT_EN to add a beat timeout. The
// counter restarts on SERVICE entry and on every wrp_ack_i; if it reaches
// TO_CYC-1 without an ack the granted master gets a one-cycle m_err_o pulse
// and the arbiter returns to IDLE. Without the macro m_err_o is tied to 0.
// -----------------------------------------------------------------------------
module sbus_arb #(
    parameter int               NM      = 3,
    parameter int               AW      = 32,
    parameter int               DW      = 32,
    parameter int               BW      = 4,
    parameter logic [NM*AW-1:0] ADR_OFS = {32'h0, 32'h0100_0000, 32'h0},
    parameter int               TO_CYC  = 256
) (
    input  logic     clk_i,
    input  logic     rst_n,
    sbus_arb_if.slave bus
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    // Configurations outside NM 2..8 / TO_CYC 1..65535 are unsupported;
    // this block exists only to flag such a parameter set in the hierarchy.
    if (NM < 2 || NM > 8 || TO_CYC < 1 || TO_CYC > 65535) begin : g_unsupported_params
    end

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] gnt_reg, gnt_next;
    logic [IW-1:0] lst_reg, lst_next;

    // ------------------------------------------------------------------
    // Per-master views of the packed buses
    // ------------------------------------------------------------------
    logic [AW-1:0] adr_arr   [NM];
    logic [DW-1:0] dat_arr   [NM];
    logic [3:0]    sel_arr   [NM];
    logic [BW-1:0] burst_arr [NM];

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_unpack
            // Sum is taken at AW bits so the offset wraps around.
            assign adr_arr[gi]   = bus.m_adr_i[gi*AW +: AW] + ADR_OFS[gi*AW +: AW];
            assign dat_arr[gi]   = bus.m_dat_i[gi*DW +: DW];
            assign sel_arr[gi]   = bus.m_sel_i[gi*4 +: 4];
            assign burst_arr[gi] = bus.m_burst_cnt_i[gi*BW +: BW];
        end
    endgenerate

    logic svc;
    logic stb_g;
    assign svc   = (state_reg == SERVICE);
    assign stb_g = bus.m_stb_i[gnt_reg];

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at lst+1, lst+2, ... modulo NM.
    // Stepping i up to NM means the last-served master is checked last.
    // ------------------------------------------------------------------
    logic          rr_hit;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] rr_cand;

    always_comb begin
        rr_hit  = 1'b0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int i = 1; i <= NM; i++) begin
            rr_cand = IW'((int'(lst_reg) + i) % NM);
            if (!rr_hit && bus.m_stb_i[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional beat timeout
    // ------------------------------------------------------------------
    logic to_hit;

`ifdef SBUS_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_reg, to_cnt_next;

    // A completing transaction or an aborting master wins over a timeout.
    assign to_hit = svc && stb_g && !bus.wrp_ack_i && !bus.wrp_ack_bus_i &&
                    (to_cnt_reg == 16'(TO_CYC - 1));

    always_comb begin
        to_cnt_next = '0;
        if (svc && !bus.wrp_ack_i) begin
            to_cnt_next = to_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_next;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            lst_reg   <= IW'(NM - 1);
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            lst_reg   <= lst_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        lst_next   = lst_reg;
        case (state_reg)
            IDLE: begin
                if (rr_hit) begin
                    state_next = SERVICE;
                    gnt_next   = rr_idx;
                end
            end
            SERVICE: begin
                if (bus.wrp_ack_bus_i || !stb_g || to_hit) begin
                    state_next = IDLE;
                    lst_next   = gnt_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: everything qualified by svc, so reset clears them at once.
    // ------------------------------------------------------------------
    logic [NM-1:0] gnt_oh;

    always_comb begin
        gnt_oh = '0;
        if (svc) begin
            gnt_oh[gnt_reg] = 1'b1;
        end
    end

    assign bus.grant_o = gnt_oh;

    generate
        for (gi = 0; gi < NM; gi++) begin : g_route
            assign bus.m_dat_o[gi*DW +: DW] = gnt_oh[gi] ? bus.wrp_dat_i : '0;
            assign bus.m_ack_o[gi]          = gnt_oh[gi] & bus.wrp_ack_i;
            assign bus.m_err_o[gi]          = gnt_oh[gi] & to_hit;
        end
    endgenerate

    assign bus.wrp_stb_o       = svc & stb_g;
    assign bus.wrp_we_o        = svc & bus.m_we_i[gnt_reg];
    assign bus.wrp_adr_o       = svc ? adr_arr[gnt_reg]   : '0;
    assign bus.wrp_dat_o       = svc ? dat_arr[gnt_reg]   : '0;
    assign bus.wrp_sel_o       = svc ? sel_arr[gnt_reg]   : '0;
    assign bus.wrp_burst_cnt_o = svc ? burst_arr[gnt_reg] : '0;

endmodule

// File: tb/tb_sbus_arb.sv
module tb_sbus_arb;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sbus_arb_if #(.NM(3), .AW(32), .DW(32), .BW(4)) bus ();

    sbus_arb #(
        .NM      (3),
        .AW      (32),
        .DW      (32),
        .BW      (4),
        .ADR_OFS ({32'h0000_0020, 32'h0100_0000, 32'h0000_0000}),
        .TO_CYC  (8)
    ) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]  stb;
        logic        ack;
        logic        ack_bus;
        logic [31:0] wdat;
        logic [2:0]  e_grant;
        logic        e_stb;
        logic        e_we;
        logic [31:0] e_adr;
        logic [2:0]  e_ack;
    } vec_t;

    vec_t        tv [21];
    logic [31:0] madr_c [3];
    logic [31:0] mdat_c [3];
    logic [3:0]  msel_c [3];
    logic [3:0]  mbur_c [3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [2:0] oh);
        int r;
        r = -1;
        for (int k = 0; k < 3; k++) if (oh[k]) r = k;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, ".grant"},   96'(bus.grant_o),   96'(0));
        chk({tag, ".wrp_stb"}, 96'(bus.wrp_stb_o), 96'(0));
        chk({tag, ".wrp_adr"}, 96'(bus.wrp_adr_o), 96'(0));
        chk({tag, ".wrp_dat"}, 96'(bus.wrp_dat_o), 96'(0));
        chk({tag, ".m_ack"},   96'(bus.m_ack_o),   96'(0));
        chk({tag, ".m_dat"},   bus.m_dat_o,        96'(0));
        chk({tag, ".m_err"},   96'(bus.m_err_o),   96'(0));
    endtask

    initial begin
        madr_c[0] = 32'h0000_0100; madr_c[1] = 32'h0000_1000; madr_c[2] = 32'hFFFF_FFF0;
        mdat_c[0] = 32'hD000_0000; mdat_c[1] = 32'hD000_0001; mdat_c[2] = 32'hD000_0002;
        msel_c[0] = 4'h1;          msel_c[1] = 4'h3;          msel_c[2] = 4'hF;
        mbur_c[0] = 4'd1;          mbur_c[1] = 4'd4;          mbur_c[2] = 4'd3;

        //         stb     ack  bus  wdat          grant   stb  we   adr            ack
        tv[0]  = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[1]  = '{3'b111, 1'b1, 1'b0, 32'hA1,       3'b001, 1'b1, 1'b0, 32'h0000_0100, 3'b001};
        tv[2]  = '{3'b111, 1'b1, 1'b1, 32'hA2,       3'b001, 1'b1, 1'b0, 32'h0000_0100, 3'b001};
        tv[3]  = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[4]  = '{3'b111, 1'b0, 1'b1, 32'h0,        3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b000};
        tv[5]  = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[6]  = '{3'b111, 1'b0, 1'b1, 32'h0,        3'b100, 1'b1, 1'b0, 32'h0000_0010, 3'b000};
        tv[7]  = '{3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[8]  = '{3'b010, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[9]  = '{3'b010, 1'b1, 1'b0, 32'hB0,       3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b010};
        tv[10] = '{3'b010, 1'b1, 1'b0, 32'hB1,       3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b010};
        tv[11] = '{3'b010, 1'b1, 1'b0, 32'hB2,       3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b010};
        tv[12] = '{3'b010, 1'b1, 1'b0, 32'hB3,       3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b010};
        tv[13] = '{3'b010, 1'b0, 1'b1, 32'h0,        3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b000};
        tv[14] = '{3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[15] = '{3'b011, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[16] = '{3'b010, 1'b0, 1'b0, 32'h0,        3'b001, 1'b0, 1'b0, 32'h0000_0100, 3'b000};
        tv[17] = '{3'b010, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};
        tv[18] = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b000};
        tv[19] = '{3'b110, 1'b0, 1'b1, 32'h0,        3'b010, 1'b1, 1'b1, 32'h0100_1000, 3'b000};
        tv[20] = '{3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,         3'b000};

        bus.m_adr_i       = {madr_c[2], madr_c[1], madr_c[0]};
        bus.m_dat_i       = {mdat_c[2], mdat_c[1], mdat_c[0]};
        bus.m_sel_i       = {msel_c[2], msel_c[1], msel_c[0]};
        bus.m_burst_cnt_i = {mbur_c[2], mbur_c[1], mbur_c[0]};
        bus.m_we_i        = 3'b010;
        bus.m_stb_i       = 3'b111;
        bus.wrp_ack_i     = 1'b1;
        bus.wrp_ack_bus_i = 1'b0;
        bus.wrp_dat_i     = 32'h5555_AAAA;
        rst_n             = 1'b0;

        // Outputs held at zero during reset even with every input active.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        $display("reset: stb=111 ack=1 -> grant=%b wrp_stb=%b", bus.grant_o, bus.wrp_stb_o);

        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            logic [95:0] e_mdat;
            int          gi_e;
            string       tag;
            bus.m_stb_i       = tv[i].stb;
            bus.wrp_ack_i     = tv[i].ack;
            bus.wrp_ack_bus_i = tv[i].ack_bus;
            bus.wrp_dat_i     = tv[i].wdat;
            @(negedge clk);
            tag    = $sformatf("v%0d", i);
            gi_e   = oh2idx(tv[i].e_grant);
            e_mdat = '0;
            if (gi_e >= 0) e_mdat[gi_e*32 +: 32] = tv[i].wdat;
            chk({tag, ".grant"},   96'(bus.grant_o),   96'(tv[i].e_grant));
            chk({tag, ".wrp_stb"}, 96'(bus.wrp_stb_o), 96'(tv[i].e_stb));
            chk({tag, ".wrp_we"},  96'(bus.wrp_we_o),  96'(tv[i].e_we));
            chk({tag, ".wrp_adr"}, 96'(bus.wrp_adr_o), 96'(tv[i].e_adr));
            chk({tag, ".m_ack"},   96'(bus.m_ack_o),   96'(tv[i].e_ack));
            chk({tag, ".m_dat"},   bus.m_dat_o,        e_mdat);
            chk({tag, ".m_err"},   96'(bus.m_err_o),   96'(0));
            chk({tag, ".wrp_dat"}, 96'(bus.wrp_dat_o), 96'((gi_e >= 0) ? mdat_c[gi_e] : 32'h0));
            chk({tag, ".wrp_sel"}, 96'(bus.wrp_sel_o), 96'((gi_e >= 0) ? msel_c[gi_e] : 4'h0));
            chk({tag, ".wrp_bc"},  96'(bus.wrp_burst_cnt_o), 96'((gi_e >= 0) ? mbur_c[gi_e] : 4'h0));
            $display("%s: stb=%b ack=%b bus=%b -> grant=%b wrp_stb=%b adr=%h m_ack=%b",
                     tag, tv[i].stb, tv[i].ack, tv[i].ack_bus,
                     bus.grant_o, bus.wrp_stb_o, bus.wrp_adr_o, bus.m_ack_o);
            @(posedge clk); #1;
        end

        // Reset asserted in the middle of a master-1 burst.
        bus.m_stb_i       = 3'b010;
        bus.wrp_ack_i     = 1'b0;
        bus.wrp_ack_bus_i = 1'b0;
        bus.wrp_dat_i     = 32'hC0DE_0001;
        @(posedge clk); #1;
        bus.wrp_ack_i = 1'b1;
        #1;
        chk("mid.grant_pre", 96'(bus.grant_o), 96'(3'b010));
        chk("mid.ack_pre",   96'(bus.m_ack_o), 96'(3'b010));
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        $display("mid-burst reset: grant=%b wrp_stb=%b m_ack=%b", bus.grant_o, bus.wrp_stb_o, bus.m_ack_o);

        @(posedge clk); #1;
        bus.m_stb_i   = 3'b111;
        bus.wrp_ack_i = 1'b0;
        rst_n         = 1'b1;

        // After release master 0 wins; then either a timeout or an
        // indefinite wait depending on the build.
`ifdef SBUS_ARB_TIMEOUT_EN
        for (int k = 0; k <= 9; k++) begin
            logic [2:0] e_g;
            logic [2:0] e_e;
            @(negedge clk);
            e_g = (k >= 1 && k <= 8) ? 3'b001 : 3'b000;
            e_e = (k == 8) ? 3'b001 : 3'b000;
            chk($sformatf("to%0d.grant", k), 96'(bus.grant_o), 96'(e_g));
            chk($sformatf("to%0d.m_err", k), 96'(bus.m_err_o), 96'(e_e));
            $display("to%0d: grant=%b m_err=%b", k, bus.grant_o, bus.m_err_o);
            @(posedge clk); #1;
        end
`else
        for (int k = 0; k <= 20; k++) begin
            logic [2:0] e_g;
            @(negedge clk);
            e_g = (k >= 1) ? 3'b001 : 3'b000;
            chk($sformatf("wait%0d.grant", k), 96'(bus.grant_o), 96'(e_g));
            chk($sformatf("wait%0d.m_err", k), 96'(bus.m_err_o), 96'(0));
            $display("wait%0d: grant=%b m_err=%b", k, bus.grant_o, bus.m_err_o);
            @(posedge clk); #1;
        end
`endif

        bus.m_stb_i = 3'b000;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
